// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs from the pipeline and the stall/flush controls returned to it
interface hazard_ctrl_if #(parameter int RA_W = 5);
  logic [RA_W-1:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_mem_read, ex_mc_start, ex_mc_done, ex_redirect, mem_wait;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read, ex_mc_start, ex_mc_done,
           ex_redirect, mem_wait,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, memwb_flush
  );
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read, ex_mc_start, ex_mc_done,
           ex_redirect, mem_wait,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, memwb_flush
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for the 5-stage pipeline; HAZ_PERF_EN adds stall/redirect counters
module hazard_ctrl #(
  parameter int RA_W   = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_ctrl_if.slave      hz,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_flush
);
  typedef enum logic [1:0] {RUN, MC_BUSY, MC_HOLD} state_t;
  localparam logic [8:0] CTL_DEF = 9'b1_1111_0000;
  localparam logic [8:0] CTL_MW  = 9'b0_0000_0001;
  localparam logic [8:0] CTL_MC  = 9'b0_0001_0010;
  localparam logic [8:0] CTL_RDR = 9'b1_0011_1100;
  localparam logic [8:0] CTL_LU  = 9'b0_0011_0100;
  state_t state, state_nx;
  logic [RA_W-1:0] rd;
  logic load_use, mc_stall;
  logic [8:0] ctl;
  assign rd = hz.ex_rd;
  assign load_use = hz.ex_mem_read && rd != '0 &&
                    ((hz.id_use_rs1 && hz.id_rs1 == rd) || (hz.id_use_rs2 && hz.id_rs2 == rd));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_nx;
  // A completion seen while memory is frozen parks in MC_HOLD so it is not dropped
  always_comb begin
    state_nx = (state == RUN)     ? ((hz.ex_mc_start && !hz.ex_mc_done) ? MC_BUSY : RUN) :
               (state == MC_BUSY) ? (!hz.ex_mc_done ? MC_BUSY : hz.mem_wait ? MC_HOLD : RUN) :
                                    (hz.mem_wait ? MC_HOLD : RUN);
    mc_stall = (state == RUN && hz.ex_mc_start && !hz.ex_mc_done) || (state == MC_BUSY && !hz.ex_mc_done);
    ctl = !rst_n         ? 9'b0 :
          hz.mem_wait    ? CTL_MW :
          mc_stall       ? CTL_MC :
          hz.ex_redirect ? CTL_RDR :
          load_use       ? CTL_LU : CTL_DEF;
  end
  assign {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
          hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.memwb_flush} = ctl;
`ifdef HAZ_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      perf_stall <= perf_stall + PERF_W'(!hz.pc_en);
      perf_flush <= perf_flush + PERF_W'(hz.ifid_flush);
    end
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif
endmodule
